// File: rtl/arb_pkg.sv
// Shared constants, FSM state type and active-low select encoding for the
// 8-way round-robin arbiter.
package arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

  // Active-low one-hot select: every bit high except the selected index.
  function automatic logic [N_REQ-1:0] idx_to_onehot_n(input logic [IDX_W-1:0] idx);
    return ~(N_REQ'(1) << idx);
  endfunction

endpackage

// File: rtl/rr_pick_8.sv
// Combinational round-robin picker: first requester at or after ptr
// (wrapping), optionally skipping one excluded index.
module rr_pick_8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             excl_en,
  input  logic [IDX_W-1:0] excl_idx,
  output logic             any,
  output logic [IDX_W-1:0] win_idx
);

  logic [IDX_W-1:0] cand;

  // Scan ptr, ptr+1, ... ptr+7 (mod 8); the first eligible requester wins.
  always_comb begin
    any     = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = ptr + IDX_W'(k);
      if (!any && req[cand] && !(excl_en && (cand == excl_idx))) begin
        any     = 1'b1;
        win_idx = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with grant hold, early release via
// done, and a maximum-hold timeout. All outputs are registered.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt_n,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam logic              HOLD_LIM_EN = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LIM    = HOLD_W'(MAX_HOLD);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
  logic [N_REQ-1:0] gnt_n_nxt;
  logic [IDX_W-1:0] gnt_idx_nxt;
  logic             gnt_valid_nxt;
  logic             timeout_nxt;

  logic             owner_req;
  logic             hold_hit;
  logic             rel;
  logic             to_rel;
  logic             excl_en;
  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;

  // Release decode for the current owner. A timeout release keeps the owner
  // eligible (it may be re-granted if alone); done or a dropped request
  // excludes it from this one arbitration.
  always_comb begin
    owner_req = req[gnt_idx];
    hold_hit  = HOLD_LIM_EN && (hold_cnt == HOLD_LIM);
    rel       = done || !owner_req || hold_hit;
    to_rel    = hold_hit && !done && owner_req;
    excl_en   = (state == GRANT) && !to_rel;
  end

  rr_pick_8 u_pick (
    .req      (req),
    .ptr      (ptr),
    .excl_en  (excl_en),
    .excl_idx (gnt_idx),
    .any      (pick_any),
    .win_idx  (pick_idx)
  );

  // Next-state and next-output logic for the IDLE/GRANT controller.
  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    hold_cnt_nxt  = hold_cnt;
    gnt_n_nxt     = gnt_n;
    gnt_idx_nxt   = gnt_idx;
    gnt_valid_nxt = gnt_valid;
    timeout_nxt   = 1'b0;

    unique case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt     = GRANT;
          gnt_idx_nxt   = pick_idx;
          gnt_n_nxt     = idx_to_onehot_n(pick_idx);
          gnt_valid_nxt = 1'b1;
          hold_cnt_nxt  = HOLD_W'(1);
          ptr_nxt       = pick_idx + IDX_W'(1);
        end else begin
          gnt_idx_nxt   = '0;
          gnt_n_nxt     = '1;
          gnt_valid_nxt = 1'b0;
          hold_cnt_nxt  = '0;
        end
      end
      GRANT: begin
        if (!rel) begin
          if (hold_cnt != '1) begin
            hold_cnt_nxt = hold_cnt + HOLD_W'(1);
          end
        end else if (pick_any) begin
          // Back-to-back handover; ptr already sits at owner+1 so the
          // releasing owner has lowest priority.
          gnt_idx_nxt   = pick_idx;
          gnt_n_nxt     = idx_to_onehot_n(pick_idx);
          gnt_valid_nxt = 1'b1;
          hold_cnt_nxt  = HOLD_W'(1);
          ptr_nxt       = pick_idx + IDX_W'(1);
          timeout_nxt   = to_rel;
        end else begin
          state_nxt     = IDLE;
          gnt_idx_nxt   = '0;
          gnt_n_nxt     = '1;
          gnt_valid_nxt = 1'b0;
          hold_cnt_nxt  = '0;
          timeout_nxt   = to_rel;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, pointer, hold counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt_n     <= '1;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      hold_cnt  <= hold_cnt_nxt;
      gnt_n     <= gnt_n_nxt;
      gnt_idx   <= gnt_idx_nxt;
      gnt_valid <= gnt_valid_nxt;
      timeout   <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Scoreboard bench for rr_arbiter_8: stimulus pushes reference-model
// predictions, a monitor pops and compares one per clock.
module tb_rr_arbiter_8;

  localparam int MAXH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = '0;
  logic       done = 1'b0;
  logic [7:0] gnt_n;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  rr_arbiter_8 #(.MAX_HOLD(16), .HOLD_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt_n     (gnt_n),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [2:0] i;
    logic [7:0] n;
    logic       t;
  } obs_t;

  obs_t q[$];
  int   total = 0;
  int   bad = 0;

  // reference model: owner (-1 = idle), search start, cycles held
  int   m_owner = -1;
  int   m_ptr = 0;
  int   m_hold = 0;
  logic m_to = 1'b0;

  task automatic check(input string nm, input obs_t act, input obs_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got v=%0b idx=%0d gnt_n=%b to=%0b, want v=%0b idx=%0d gnt_n=%b to=%0b",
               nm, act.v, act.i, act.n, act.t, exp.v, exp.i, exp.n, exp.t);
    end
  endtask

  function automatic obs_t mk(input int owner, input logic to);
    obs_t o;
    logic [7:0] one;
    one = 8'h01;
    o.v = (owner >= 0);
    o.i = (owner >= 0) ? owner[2:0] : 3'd0;
    o.n = (owner >= 0) ? ~(one << owner) : 8'hFF;
    o.t = to;
    return o;
  endfunction

  function automatic int find(input logic [7:0] r, input int p, input int ex);
    for (int k = 0; k < 8; k++) begin
      int i;
      i = (p + k) % 8;
      if (r[i] && i != ex) return i;
    end
    return -1;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.v = gnt_valid;
    o.i = gnt_idx;
    o.n = gnt_n;
    o.t = timeout;
    return o;
  endfunction

  task automatic model_step(input logic [7:0] r, input logic d);
    int w;
    m_to = 1'b0;
    if (m_owner < 0) begin
      w = find(r, m_ptr, -1);
      if (w >= 0) begin
        m_owner = w; m_hold = 1; m_ptr = (w + 1) % 8;
      end
    end else begin
      logic dropped, hit;
      dropped = !r[m_owner];
      hit     = (MAXH != 0) && (m_hold == MAXH);
      if (!d && !dropped && !hit) begin
        if (m_hold < 31) m_hold++;
      end else begin
        m_to = hit && !d && !dropped;
        w = find(r, m_ptr, m_to ? -1 : m_owner);
        if (w >= 0) begin
          m_owner = w; m_hold = 1; m_ptr = (w + 1) % 8;
        end else begin
          m_owner = -1; m_hold = 0;
        end
      end
    end
  endtask

  // drive one cycle of inputs and enqueue the predicted registered response
  task automatic cyc(input logic [7:0] r, input logic d);
    @(negedge clk);
    req  = r;
    done = d;
    model_step(r, d);
    q.push_back(mk(m_owner, m_to));
  endtask

  // directed check of outputs just after the next rising edge
  task automatic see(input string nm, input int owner, input logic to);
    @(posedge clk);
    #2;
    check(nm, dut_obs(), mk(owner, to));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    q.delete();
    m_owner = -1; m_ptr = 0; m_hold = 0; m_to = 1'b0;
    #1;
    check("reset_async", dut_obs(), mk(-1, 1'b0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // monitor: one prediction per clock once stimulus has issued it
  always @(posedge clk) begin
    #1;
    if (rst_n && q.size() > 0) begin
      obs_t e;
      e = q.pop_front();
      check("scoreboard", dut_obs(), e);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] r;
    logic       d;

    do_reset();
    for (int t = 0; t < 10; t++) begin
      cyc(8'h00, 1'b0);
      see("idle_no_req", -1, 1'b0);
    end

    // single request, hold, then drop
    cyc(8'b0000_0100, 1'b0);
    see("single_grant", 2, 1'b0);
    for (int t = 0; t < 5; t++) begin
      cyc(8'b0000_0100, 1'b0);
      see("single_hold", 2, 1'b0);
    end
    cyc(8'h00, 1'b0);
    see("single_drop", -1, 1'b0);

    // full rotation with done on the 3rd cycle of each grant
    do_reset();
    for (int t = 0; t < 27; t++) begin
      cyc(8'hFF, (m_owner >= 0) && (m_hold == 3));
      see("rotation", (t / 3) % 8, 1'b0);
    end

    // timeout alternation between 0 and 4
    do_reset();
    for (int t = 0; t < 48; t++) begin
      cyc(8'b0001_0001, 1'b0);
      see("timeout_pair", ((t / 16) % 2 == 1) ? 4 : 0, (t > 0) && (t % 16 == 0));
    end

    // lone requester is re-granted on each timeout
    do_reset();
    for (int t = 0; t < 40; t++) begin
      cyc(8'b0000_0001, 1'b0);
      see("timeout_alone", 0, (t > 0) && (t % 16 == 0));
    end

    // release priority: owner 5 releases, 0 wins, ptr then at 1
    do_reset();
    cyc(8'b0010_0000, 1'b0);
    see("prio_owner5", 5, 1'b0);
    cyc(8'b0010_0001, 1'b1);
    see("prio_next0", 0, 1'b0);
    cyc(8'b0010_0011, 1'b1);
    see("prio_ptr1", 1, 1'b0);

    // done with owner as only requester goes idle, then re-grants
    cyc(8'b0000_0010, 1'b1);
    see("done_alone_idle", -1, 1'b0);
    cyc(8'b0000_0010, 1'b0);
    see("done_alone_regrant", 1, 1'b0);

    // reset in the middle of a grant to 3
    do_reset();
    cyc(8'b0000_1000, 1'b0);
    see("mid_grant3", 3, 1'b0);
    cyc(8'b0000_1000, 1'b0);
    see("mid_hold3", 3, 1'b0);
    do_reset();
    cyc(8'b0000_1001, 1'b0);
    see("post_reset_ptr0", 0, 1'b0);

    // randomized traffic against the model
    do_reset();
    r = 8'($urandom);
    for (int t = 0; t < 1500; t++) begin
      if (t < 750) r = r ^ 8'($urandom & $urandom & $urandom);
      else         r = r ^ 8'($urandom & $urandom & $urandom & $urandom);
      d = ($urandom_range(0, 7) == 0);
      cyc(r, d);
    end
    cyc(8'h00, 1'b0);
    @(posedge clk);
    #3;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
